f3_window_reader: RTL and testbench

- Reader side of the six-bank F3 feature-map RAM. Each bank holds one 14x14 map of 16-bit words, 196 entries at addresses 0..195, row-major.
- Scans all six maps in lock-step and drives f3_raddr.
- Absorbs the RAM's registered read latency and streams 5x5 convolution windows (stride 1, 10x10 output positions) to the C3 conv engine over a valid/ready interface.

---
 rtl/lenet_pkg.sv | 16 +
 rtl/f3_rd_buf.sv | 42 ++++
 rtl/f3_window_reader.sv | 167 ++++++++++++++++
 tb/tb_f3_window_reader.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
// lenet_pkg: shared constants, scan FSM states and the tap tag carried alongside each RAM read.
package lenet_pkg;
  localparam int DW = 16;
  localparam int N_CH = 6;
  localparam int F3_MAP_W = 14;
  localparam int F3_MAP_H = 14;
  localparam int C3_K = 5;
  localparam int F3_AW = 8;
  localparam int C3_OUT = F3_MAP_W - C3_K + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} f3_state_e;
  typedef struct packed {
    logic first;
    logic last;
    logic frame_last;
  } tap_tag_t;
endpackage

// File: rtl/f3_rd_buf.sv
// f3_rd_buf: small synchronous FIFO that absorbs RAM read returns; head reads as zero when empty.
module f3_rd_buf import lenet_pkg::*; #(
  parameter int W = N_CH * DW + 3,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en_i,
  input  logic [W-1:0]                   wr_data_i,
  input  logic                           rd_en_i,
  output logic [W-1:0]                   rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o,
  output logic                           full_o,
  output logic                           empty_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en_i) wp_q <= nxt(wp_q);
      if (rd_en_i) rp_q <= nxt(rp_q);
      cnt_q <= cnt_q + CW'(wr_en_i) - CW'(rd_en_i);
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wp_q] <= wr_data_i;
  end
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == CW'(DEPTH);
  assign count_o = cnt_q;
  assign rd_data_o = empty_o ? '0 : mem_q[rp_q];
endmodule

// File: rtl/f3_window_reader.sv
// f3_window_reader: scans the six F3 maps as 5x5 stride-1 windows and streams taps over valid/ready.
// Define F3_RD_STALL_CNT_EN to add the stall_cnt backpressure counter output.
module f3_window_reader import lenet_pkg::*; #(
  parameter int MAP_W = F3_MAP_W,
  parameter int MAP_H = F3_MAP_H,
  parameter int K = C3_K,
  parameter int DW = lenet_pkg::DW,
  parameter int AW = F3_AW,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [AW-1:0]        f3_raddr,
  input  logic [DW-1:0]        f3_1_rdata,
  input  logic [DW-1:0]        f3_2_rdata,
  input  logic [DW-1:0]        f3_3_rdata,
  input  logic [DW-1:0]        f3_4_rdata,
  input  logic [DW-1:0]        f3_5_rdata,
  input  logic [DW-1:0]        f3_6_rdata,
  output logic                 tap_valid,
  input  logic                 tap_ready,
  output logic [N_CH*DW-1:0]   tap_data,
  output logic                 tap_first,
  output logic                 tap_last,
  output logic                 frame_last
`ifdef F3_RD_STALL_CNT_EN
  ,output logic [15:0]         stall_cnt
`endif
);
  localparam int DEPTH = RD_LAT + 1;
  localparam int BW = N_CH * DW + 3;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam logic [3:0] KM1 = 4'(K - 1);
  localparam logic [3:0] CM1 = 4'(MAP_W - K);
  localparam logic [3:0] RM1 = 4'(MAP_H - K);
  localparam logic [AW-1:0] ROW_STEP = AW'(MAP_W);
  localparam logic [AW-1:0] WIN_STEP = AW'(K);
  f3_state_e st_q, st_d;
  logic [3:0] r_q, r_d, c_q, c_d, kr_q, kr_d, kc_q, kc_d;
  logic [AW-1:0] win_q, win_d, row_q, row_d, raddr_q, raddr_d;
  logic [RD_LAT-1:0] vld_q;
  tap_tag_t tag_q [RD_LAT];
  tap_tag_t iss_tag, out_tag;
  logic [CNTW-1:0] buf_cnt;
  logic buf_full, buf_empty;
  logic [BW-1:0] buf_rd;
  logic scan, issue, pop, last_pos;
  logic [7:0] used;
  assign scan = st_q == RUN || (st_q == IDLE && start);
  assign pop = tap_valid && tap_ready;
  assign used = 8'(buf_cnt) + 8'($countones(vld_q));
  // credit check: buffered plus in-flight reads must leave room, counting this cycle's pop
  assign issue = scan && (!buf_full || pop) && used < 8'(DEPTH) + 8'(pop);
  assign last_pos = kc_q == KM1 && kr_q == KM1 && c_q == CM1 && r_q == RM1;
  assign iss_tag = '{first: kr_q == '0 && kc_q == '0, last: kr_q == KM1 && kc_q == KM1, frame_last: last_pos};
  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:    st_d = start ? RUN : IDLE;
      RUN:     st_d = (issue && last_pos) ? DRAIN : RUN;
      DRAIN:   st_d = (pop && out_tag.frame_last) ? DONE : DRAIN;
      default: st_d = IDLE;
    endcase
  end
  // the final issue wraps every counter back to zero, so IDLE always sits at address 0
  always_comb begin
    r_d = r_q;
    c_d = c_q;
    kr_d = kr_q;
    kc_d = kc_q;
    win_d = win_q;
    row_d = row_q;
    raddr_d = raddr_q;
    if (issue) begin
      if (kc_q != KM1) begin
        kc_d = kc_q + 1'b1;
        raddr_d = raddr_q + 1'b1;
      end else if (kr_q != KM1) begin
        kc_d = '0;
        kr_d = kr_q + 1'b1;
        row_d = row_q + ROW_STEP;
        raddr_d = row_q + ROW_STEP;
      end else if (c_q != CM1) begin
        kc_d = '0;
        kr_d = '0;
        c_d = c_q + 1'b1;
        win_d = win_q + 1'b1;
        row_d = win_q + 1'b1;
        raddr_d = win_q + 1'b1;
      end else if (r_q != RM1) begin
        kc_d = '0;
        kr_d = '0;
        c_d = '0;
        r_d = r_q + 1'b1;
        win_d = win_q + WIN_STEP;
        row_d = win_q + WIN_STEP;
        raddr_d = win_q + WIN_STEP;
      end else begin
        kc_d = '0;
        kr_d = '0;
        c_d = '0;
        r_d = '0;
        win_d = '0;
        row_d = '0;
        raddr_d = '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      r_q <= '0;
      c_q <= '0;
      kr_q <= '0;
      kc_q <= '0;
      win_q <= '0;
      row_q <= '0;
      raddr_q <= '0;
      vld_q <= '0;
    end else begin
      st_q <= st_d;
      r_q <= r_d;
      c_q <= c_d;
      kr_q <= kr_d;
      kc_q <= kc_d;
      win_q <= win_d;
      row_q <= row_d;
      raddr_q <= raddr_d;
      vld_q <= RD_LAT'({vld_q, issue});
    end
  end
  always_ff @(posedge clk) begin
    tag_q[0] <= iss_tag;
    for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
  end
  f3_rd_buf #(.W(BW), .DEPTH(DEPTH)) u_buf (
    .clk(clk),
    .rst(rst),
    .wr_en_i(vld_q[RD_LAT-1]),
    .wr_data_i({tag_q[RD_LAT-1], f3_6_rdata, f3_5_rdata, f3_4_rdata, f3_3_rdata, f3_2_rdata, f3_1_rdata}),
    .rd_en_i(pop),
    .rd_data_o(buf_rd),
    .count_o(buf_cnt),
    .full_o(buf_full),
    .empty_o(buf_empty)
  );
  assign out_tag = tap_tag_t'(buf_rd[BW-1 -: 3]);
  assign tap_valid = !buf_empty;
  assign tap_data = buf_rd[N_CH*DW-1:0];
  assign tap_first = out_tag.first;
  assign tap_last = out_tag.last;
  assign frame_last = out_tag.frame_last;
  assign busy = st_q == RUN || st_q == DRAIN;
  assign done = st_q == DONE;
  assign f3_raddr = raddr_q;
`ifdef F3_RD_STALL_CNT_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk) begin
    if (rst || (st_q == IDLE && start)) stall_q <= '0;
    else if (tap_valid && !tap_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 1'b1;
  end
  assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_f3_window_reader.sv
// tb_f3_window_reader: directed frames against a ramp-loaded registered-read RAM model.
module tb_f3_window_reader;
  logic clk = 0, rst = 1, start = 0, tap_ready = 0;
  logic busy, done, tap_valid, tap_first, tap_last, frame_last;
  logic [7:0] f3_raddr;
  logic [15:0] rd1, rd2, rd3, rd4, rd5, rd6;
  logic [95:0] tap_data;
`ifdef F3_RD_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif
  int n_chk = 0, n_err = 0, beats = 0, done_cnt = 0, bubbles = 0, cyc = 0, last_cyc = 0;
  logic stall_prev = 0;
  logic [98:0] prev_snap = '0;
  logic [98:0] snap;
  assign snap = {tap_first, tap_last, frame_last, tap_data};

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    rd1 <= {8'd1, f3_raddr};
    rd2 <= {8'd2, f3_raddr};
    rd3 <= {8'd3, f3_raddr};
    rd4 <= {8'd4, f3_raddr};
    rd5 <= {8'd5, f3_raddr};
    rd6 <= {8'd6, f3_raddr};
  end

  f3_window_reader dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .f3_raddr(f3_raddr),
    .f3_1_rdata(rd1), .f3_2_rdata(rd2), .f3_3_rdata(rd3),
    .f3_4_rdata(rd4), .f3_5_rdata(rd5), .f3_6_rdata(rd6),
    .tap_valid(tap_valid), .tap_ready(tap_ready), .tap_data(tap_data),
    .tap_first(tap_first), .tap_last(tap_last), .frame_last(frame_last)
`ifdef F3_RD_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [98:0] exp_beat(input int idx);
    int w, t, r, c, kr, kc;
    logic [7:0] a;
    w = idx / 25; t = idx % 25;
    r = w / 10; c = w % 10;
    kr = t / 5; kc = t % 5;
    a = 8'((r + kr) * 14 + c + kc);
    return {(kr == 0 && kc == 0), (kr == 4 && kc == 4), (idx == 2499),
            8'd6, a, 8'd5, a, 8'd4, a, 8'd3, a, 8'd2, a, 8'd1, a};
  endfunction

  always @(negedge clk) begin
    if (rst) stall_prev = 0;
    else begin
      if (stall_prev) chk("stable", {tap_valid, snap}, {1'b1, prev_snap});
      if (tap_valid && tap_ready) begin
        chk("beat", snap, exp_beat(beats));
        case (beats)
          0:    chk("b0", {tap_data[95:80], tap_data[15:0], tap_first}, {16'h0600, 16'h0100, 1'b1});
          5:    chk("b5", tap_data[15:0], 16'h010E);
          24:   chk("b24_last", tap_last, 1);
          25:   chk("b25", {tap_data[15:0], tap_first}, {16'h0101, 1'b1});
          2499: chk("b2499", {tap_data[95:80], frame_last}, {16'h06C3, 1'b1});
          default: ;
        endcase
        if (frame_last) last_cyc = cyc;
        beats++;
      end else if (beats > 0 && beats < 2500 && !tap_valid) bubbles++;
      if (done) begin
        done_cnt++;
        chk("done_edge", cyc - last_cyc, 1);
      end
      stall_prev = tap_valid && !tap_ready;
      prev_snap = snap;
    end
  end

  task automatic run_frame(input int mode);
    int stall_left, lat, chg;
    bit pulsed, aborted;
    logic [7:0] frz, pa;
    beats = 0; done_cnt = 0; bubbles = 0;
    pulsed = 0; aborted = 0; chg = 0; frz = '0; pa = '0;
    stall_left = (mode == 2) ? 50 : (mode == 5) ? 37 : 0;
    @(posedge clk); #1 start = 1; tap_ready = 1;
    @(posedge clk); #1 start = 0;
    if (mode == 0) begin
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
        if (lat == 1) begin
          chk("busy_rise", busy, 1);
`ifdef F3_RD_STALL_CNT_EN
          chk("stall_clr", stall_cnt, 0);
`endif
        end
      end while (!tap_valid && lat < 10);
      chk("first_lat", lat, 2);
    end
    for (int n = 0; n < 8000 && done_cnt == 0 && !aborted; n++) begin
      @(posedge clk); #1;
      tap_ready = (mode == 1) ? ($urandom_range(0, 99) < 70) : 1'b1;
      start = (mode == 3 && beats >= 300 && !pulsed);
      if (start) pulsed = 1;
      if (stall_left > 0 && beats >= (mode == 2 ? 1000 : 500)) begin
        tap_ready = 0;
        if (mode == 2 && stall_left < 50 && f3_raddr != pa) chg++;
        pa = f3_raddr;
        if (stall_left == 45) frz = f3_raddr;
        stall_left--;
        if (mode == 2 && stall_left == 0) begin
          chk("raddr_frozen", f3_raddr, frz);
          chk("stall_issue_le2", chg <= 2, 1);
        end
      end
      if (mode == 4 && beats >= 1000) begin
        rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("rst_mid", {tap_valid, busy, done, f3_raddr}, 0);
        aborted = 1;
      end
    end
    start = 0;
    tap_ready = 1;
    if (!aborted) begin
      repeat (3) @(posedge clk);
      chk("done_cnt", done_cnt, 1);
      chk("beats", beats, 2500);
      chk("busy_fall", busy, 0);
      if (mode == 0) chk("bubbles", bubbles, 0);
`ifdef F3_RD_STALL_CNT_EN
      if (mode == 5) chk("stall_cnt", stall_cnt, 37);
`endif
    end
  endtask

  initial begin
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset", {busy, done, tap_valid, tap_first, tap_last, frame_last, f3_raddr, tap_data}, 0);
    @(posedge clk); #1 rst = 0;
    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(3);
    run_frame(4);
    run_frame(0);
`ifdef F3_RD_STALL_CNT_EN
    run_frame(5);
    run_frame(0);
`endif
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
